mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer that shares one single-ported data/instruction memory between the pipeline's instruction-fetch stage and the memory-access stage. It arbitrates the two requesters, runs a variable-latency req/ack transaction to the memory, and returns per-port acknowledgements and stall signals. The pipeline uses these stall signals to freeze IF/ID and the PC (fetch side) or the back end (data side) while a port waits.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (used only with ARB_STARVE_GUARD_EN); legal range 1..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  asynchronous reset, active-high.
- Fetch port:
  - i_req  in  1  fetch request; held with i_addr until i_ack.
  - i_addr  in  ADDR_W  fetch address.
  - i_rdata  out  DATA_W  fetched word; valid only while i_ack=1.
  - i_ack  out  1  fetch completion, one-cycle pulse.
- Data port:
  - d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack.
  - d_we  in  1  1=write, 0=read.
  - d_addr  in  ADDR_W  data address.
  - d_wdata  in  DATA_W  store data.
  - d_rdata  out  DATA_W  load data; valid only while d_ack=1.
  - d_ack  out  1  data completion, one-cycle pulse.
- Memory side:
  - m_req  out  1  memory request, registered.
  - m_we  out  1  write enable, registered.
  - m_addr  out  ADDR_W  registered address.
  - m_wdata  out  DATA_W  registered write data.
  - m_rdata  in  DATA_W  memory read data, valid with m_ack.
  - m_ack  in  1  memory completion, one cycle.
- Status:
  - if_stall  out  1  i_req & ~i_ack.
  - mem_stall  out  1  d_req & ~d_ack.
  - gnt_d  out  1  1 while BUSY_D.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If d_req and the starvation guard is not forcing fetch: go to BUSY_D. Latch m_addr=d_addr, m_we=d_we, m_wdata=d_wdata; set m_req=1.
  - Else if i_req: go to BUSY_I. Latch m_addr=i_addr, m_we=0, m_wdata unchanged; set m_req=1.
  - Else stay in IDLE.
- BUSY_x:
  - m_req is held at 1 and the latched fields are held stable.
  - On m_ack=1, x_ack=1 combinationally in the same cycle and x_rdata=m_rdata. At the next edge: state goes to IDLE, m_req=0, m_we=0.
- i_rdata and d_rdata both pass m_rdata through. They are defined only while the matching ack is high.
- m_ack while IDLE is ignored; no ack is produced.
- Requester rule: after seeing ack, a requester either drops req or presents a new request in the next cycle. The arbiter re-arbitrates that cycle in IDLE.
- Simultaneous i_req and d_req in IDLE: data wins (strict priority, unless the guard is active).
- Requests changed mid-transaction have no effect. The latched values are used.

## Timing
- Requests sampled in IDLE at cycle N give m_req=1 from cycle N+1.
- Earliest m_ack is at N+1, so the earliest x_ack is at N+1. The state returns to IDLE at N+2.
- Minimum access is 2 cycles. Peak throughput is one transfer per 2 cycles.
- With a memory latency of L cycles after m_req rises, x_ack occurs at N+L.
- Reset value of every output:
  - m_req=0, m_we=0, m_addr=0, m_wdata=0.
  - i_ack=0, d_ack=0, gnt_d=0.
  - state=IDLE, starvation count=0.
- if_stall and mem_stall follow the request inputs combinationally, including during reset.
- Reset asserted mid-transaction:
  - Immediately returns the block to IDLE and m_req=0.
  - No ack is produced for the aborted access.
  - A later stray m_ack is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each BUSY_D grant taken while i_req=1.
  - It clears on any BUSY_I grant and on any IDLE cycle with i_req=0.
  - When the count equals STARVE_MAX, the next IDLE arbitration grants fetch even if d_req=1.
- ARB_STARVE_GUARD_EN undefined:
  - Strict data priority.
  - No counter is present.
  - The STARVE_MAX parameter is ignored.

## Structure
- Package mem_arb_pkg holds:
  - the state encoding (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10);
  - the counter width constant STARVE_CNT_W=4.
- Sub-module arb_starve_counter (count, clear, saturate-compare) is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Fetch read: i_req, i_addr=0x40, memory acks 1 cycle after m_req with m_rdata=0x2002000A -> m_req at N+1, i_ack and i_rdata=0x2002000A at N+1, m_req=0 at N+2.
- Collision:
  - Stimulus: i_req and d_req with d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF in the same cycle.
  - Response: BUSY_D with m_we=1 and m_addr=0x100 first; if_stall=1 throughout; BUSY_I granted right after d_ack.
- Latency: memory acks 5 cycles after m_req -> m_req and m_addr stable for all 5 cycles; mem_stall=1 until the ack cycle; exactly one d_ack pulse.
- Reset mid-access: rst asserted in BUSY_I before m_ack -> m_req=0 immediately; no i_ack; m_ack pulsed after reset produces no ack.
- Guard (macro on, STARVE_MAX=2): d_req held continuously with i_req pending -> grant order D, D, I, D, D, I.
- Guard (macro off): same stimulus -> fetch never granted while d_req=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding and the
// starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusyI = 2'b01,
    StBusyD = 2'b10
  } arbState_t;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts back-to-back data grants taken while fetch is waiting and flags when
// the tolerated limit is reached.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic incr,
  input  logic clear,
  output logic atMax
);

  logic [STARVE_CNT_W-1:0] cntQ;

  assign atMax = (cntQ == STARVE_CNT_W'(STARVE_MAX));

  // Clear wins over increment; the count saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntQ <= '0;
    end else if (clear) begin
      cntQ <= '0;
    end else if (incr && !atMax) begin
      cntQ <= cntQ + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// Data has strict priority; define ARB_STARVE_GUARD_EN to force a fetch grant
// after STARVE_MAX consecutive data grants taken while fetch was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              gnt_d
);

  arbState_t         stateQ, stateD;
  logic              grantI, grantD;
  logic              forceFetch;
  logic              mReqQ, mWeQ;
  logic [ADDR_W-1:0] mAddrQ;
  logic [DATA_W-1:0] mWdataQ;

`ifdef ARB_STARVE_GUARD_EN
  logic starveAtMax;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) uStarve (
    .clk  (clk),
    .rst  (rst),
    .incr (grantD & i_req),
    .clear(grantI | ((stateQ == StIdle) & ~i_req)),
    .atMax(starveAtMax)
  );

  assign forceFetch = starveAtMax & i_req;
`else
  logic unusedStarveMax;
  assign unusedStarveMax = ^STARVE_MAX;
  assign forceFetch      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and grant decode; arbitration only happens in idle.
  always_comb begin
    stateD = stateQ;
    grantI = 1'b0;
    grantD = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (d_req && !forceFetch) begin
          stateD = StBusyD;
          grantD = 1'b1;
        end else if (i_req) begin
          stateD = StBusyI;
          grantI = 1'b1;
        end
      end
      StBusyI, StBusyD: begin
        if (m_ack) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // Per-port acks are combinational on m_ack so the requester sees completion
  // in the same cycle the memory answers.
  always_comb begin
    i_ack = (stateQ == StBusyI) & m_ack;
    d_ack = (stateQ == StBusyD) & m_ack;
    gnt_d = (stateQ == StBusyD);
  end

  // Memory-side request registers: latched on grant, held until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mReqQ   <= 1'b0;
      mWeQ    <= 1'b0;
      mAddrQ  <= '0;
      mWdataQ <= '0;
    end else if (grantD) begin
      mReqQ   <= 1'b1;
      mWeQ    <= d_we;
      mAddrQ  <= d_addr;
      mWdataQ <= d_wdata;
    end else if (grantI) begin
      mReqQ  <= 1'b1;
      mWeQ   <= 1'b0;
      mAddrQ <= i_addr;
    end else if ((stateQ != StIdle) && m_ack) begin
      mReqQ <= 1'b0;
      mWeQ  <= 1'b0;
    end
  end

  assign m_req     = mReqQ;
  assign m_we      = mWeQ;
  assign m_addr    = mAddrQ;
  assign m_wdata   = mWdataQ;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign if_stall  = i_req & ~i_ack;
  assign mem_stall = d_req & ~d_ack;

endmodule
